// File: rtl/pipelined_multiplier_pkg.sv
// Shared types and default widths for the pipelined Booth multiplier.
package multiplier_params;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_TAG_WIDTH  = 5;

  // Operation encoding; 2'b11 is decoded as MUL by the datapath.
  typedef enum logic [1:0] {
    MUL  = 2'b00,
    MADD = 2'b01,
    MSUB = 2'b10
  } mul_op_t;

endpackage

// File: rtl/pipelined_multiplier_booth_partial_product.sv
// One radix-4 Booth row: selects 0/x/2x, applies the (optionally inverted)
// sign as a one's complement, sign-extends to the product width and shifts
// into position. The +1 of the two's complement is returned as neg_o and is
// injected at bit 2*ROW by the reduction tree.
module booth_partial_product #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROW        = 0
) (
  input  logic [DATA_WIDTH:0]     mcand_i,   // multiplicand, already sign/zero extended by one bit
  input  logic [2:0]              bits_i,    // Booth triplet {y[2i+1], y[2i], y[2i-1]}
  input  logic                    invert_i,  // negate the whole product (MSUB)
  output logic [2*DATA_WIDTH-1:0] row_o,
  output logic                    neg_o
);

  localparam int unsigned MW    = DATA_WIDTH + 2;
  localparam int unsigned RW    = 2 * DATA_WIDTH;
  localparam int unsigned SHIFT = 2 * ROW;

  logic          sel_one;
  logic          sel_two;
  logic          neg;
  logic [MW-1:0] mag;
  logic [MW-1:0] val;
  logic [RW-1:0] ext;

  // Booth digit decode and row formation.
  always_comb begin
    sel_one = bits_i[0] ^ bits_i[1];
    sel_two = (bits_i[2] & ~bits_i[1] & ~bits_i[0]) |
              (~bits_i[2] & bits_i[1] & bits_i[0]);
    neg     = bits_i[2] ^ invert_i;
    mag     = '0;
    if (sel_one) begin
      mag = {mcand_i[DATA_WIDTH], mcand_i};
    end else if (sel_two) begin
      mag = {mcand_i, 1'b0};
    end
    val   = neg ? ~mag : mag;
    ext   = {{(RW - MW){val[MW-1]}}, val};
    row_o = ext << SHIFT;
    neg_o = neg;
  end

endmodule

// File: rtl/pipelined_multiplier.sv
// Two-stage pipelined radix-4 Booth multiplier with valid/ready handshake,
// flush and sideband tag. S1 registers Booth rows, S2 registers the reduced
// result. Optional multiply-accumulate under MULTIPLIER_ACCUMULATE_EN.
module pipelined_multiplier
  import multiplier_params::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH  = DEFAULT_TAG_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_signed,
  input  logic [1:0]              in_op,
  input  logic [DATA_WIDTH-1:0]   in_src1,
  input  logic [DATA_WIDTH-1:0]   in_src2,
  input  logic [2*DATA_WIDTH-1:0] in_acc,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int unsigned RW    = 2 * DATA_WIDTH;
  localparam int unsigned NROWS = DATA_WIDTH / 2 + 1;

  typedef struct packed {
    logic [NROWS-1:0][RW-1:0] rows;
    logic [RW-1:0]            negs;
`ifdef MULTIPLIER_ACCUMULATE_EN
    logic [RW-1:0]            acc;
`endif
    logic [TAG_WIDTH-1:0]     tag;
  } s1_t;

  logic                     s1_valid_q;
  logic                     out_valid_q;
  s1_t                      s1_q;
  s1_t                      s1_d;
  logic [RW-1:0]            result_q;
  logic [RW-1:0]            result_d;
  logic [TAG_WIDTH-1:0]     tag_q;

  logic                     s2_adv;
  logic                     s1_adv;
  logic                     accept;
  logic                     invert;
  logic [DATA_WIDTH:0]      mcand;
  logic [DATA_WIDTH+2:0]    ybooth;
  logic [NROWS-1:0][RW-1:0] rows_d;
  logic [NROWS-1:0]         negs_d;

`ifdef MULTIPLIER_ACCUMULATE_EN
  mul_op_t                  op_c;
  logic [RW-1:0]            acc_sel;

  // Decode accumulate operations; MSUB negates the product inside the rows.
  always_comb begin
    op_c    = mul_op_t'(in_op);
    invert  = (op_c == MSUB);
    acc_sel = ((op_c == MADD) || (op_c == MSUB)) ? in_acc : '0;
  end
`else
  logic                     unused_acc_c;

  // Accumulate disabled: op and accumulator are ignored.
  assign invert       = 1'b0;
  assign unused_acc_c = ^{in_op, in_acc};
`endif

  // Handshake: S2 drains when empty or consumed, S1 follows S2.
  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & s1_adv & ~flush;

  // Operand extension: one extra bit makes unsigned operands positive.
  assign mcand  = {in_signed & in_src1[DATA_WIDTH-1], in_src1};
  assign ybooth = {{2{in_signed & in_src2[DATA_WIDTH-1]}}, in_src2, 1'b0};

  // Booth row generators, one per radix-4 digit.
  for (genvar i = 0; i < NROWS; i++) begin : g_row
    booth_partial_product #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW        (i)
    ) u_row (
      .mcand_i  (mcand),
      .bits_i   (ybooth[2*i+2 -: 3]),
      .invert_i (invert),
      .row_o    (rows_d[i]),
      .neg_o    (negs_d[i])
    );
  end

  // Assemble the S1 payload; negate bits land at each row's LSB position.
  always_comb begin
    s1_d      = '0;
    s1_d.rows = rows_d;
    for (int i = 0; i < int'(NROWS); i++) begin
      s1_d.negs[2*i] = negs_d[i];
    end
`ifdef MULTIPLIER_ACCUMULATE_EN
    s1_d.acc  = acc_sel;
`endif
    s1_d.tag  = in_tag;
  end

  // Carry-save reduction of all rows (plus accumulator) then one CPA.
  always_comb begin
    logic [RW-1:0] s;
    logic [RW-1:0] c;
    logic [RW-1:0] t;
    logic [RW-1:0] m;
    s = s1_q.rows[0];
    c = s1_q.rows[1];
    for (int k = 2; k < int'(NROWS); k++) begin
      t = s ^ c ^ s1_q.rows[k];
      m = (s & c) | (s & s1_q.rows[k]) | (c & s1_q.rows[k]);
      s = t;
      c = m << 1;
    end
    t = s ^ c ^ s1_q.negs;
    m = (s & c) | (s & s1_q.negs) | (c & s1_q.negs);
    s = t;
    c = m << 1;
`ifdef MULTIPLIER_ACCUMULATE_EN
    t = s ^ c ^ s1_q.acc;
    m = (s & c) | (s & s1_q.acc) | (c & s1_q.acc);
    s = t;
    c = m << 1;
`endif
    result_d = s + c;
  end

  // Stage valid bits: async reset, flush clears both.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q  <= accept;
      if (s2_adv) out_valid_q <= s1_valid_q;
    end
  end

  // S1 payload register, loaded only on acceptance.
  always_ff @(posedge clock) begin
    if (accept) s1_q <= s1_d;
  end

  // S2 output register; holds while stalled.
  always_ff @(posedge clock) begin
    if (s2_adv && s1_valid_q) begin
      result_q <= result_d;
      tag_q    <= s1_q.tag;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed self-checking bench for pipelined_multiplier (32-bit operands).
module tb_pipelined_multiplier;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;
`ifdef MULTIPLIER_ACCUMULATE_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_signed = 1'b0;
  logic [1:0]      in_op = 2'b00;
  logic [W-1:0]    in_src1 = '0;
  logic [W-1:0]    in_src2 = '0;
  logic [2*W-1:0]  in_acc = '0;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*W-1:0]  out_result;
  logic [TW-1:0]   out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sgn;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [63:0] exp_acc;
    logic [63:0] exp_mul;
  } vec_t;

  vec_t vecs[10];

  pipelined_multiplier #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_acc     (in_acc),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sgn, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] acc, input logic [TW-1:0] tag);
    in_valid  = v;
    in_signed = sgn;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    in_acc    = acc;
    in_tag    = tag;
  endtask

  // Issue one request with an empty pipe and check the two-cycle latency.
  task automatic run_single(input string name, input logic sgn, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] acc, input logic [TW-1:0] tag,
                            input logic [63:0] exp);
    out_ready = 1'b1;
    drive(1'b1, sgn, op, a, b, acc, tag);
    #1;
    check_eq({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check_eq({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    check_eq({name, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({name, "_result"}, out_result, exp);
    check_eq({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  initial begin
    logic [63:0] exp_res[4];
    logic [63:0] prev_res;
    logic [TW-1:0] prev_tag;
    bit   have_prev;
    int   sent;
    int   got;

    vecs[0] = '{1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
    vecs[2] = '{1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{1'b1, 2'b00, 32'h8000_0000, 32'h0000_0001, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000};
    vecs[4] = '{1'b0, 2'b01, 32'd7, 32'd6, 64'd1, 64'd43, 64'd42};
    vecs[5] = '{1'b0, 2'b10, 32'd3, 32'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 64'd15};
    vecs[6] = '{1'b1, 2'b11, 32'd5, 32'hFFFF_FFFD, 64'd100, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[7] = '{1'b1, 2'b01, 32'hFFFF_FFFF, 32'd1, 64'h10, 64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8] = '{1'b0, 2'b00, 32'h8000_0000, 32'd2, 64'd0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000};
    vecs[9] = '{1'b1, 2'b10, 32'hFFFF_FFFE, 32'd3, 64'd100, 64'h0000_0000_0000_006A, 64'hFFFF_FFFF_FFFF_FFFA};

    // Reset behaviour
    #1;
    check_eq("rst_out_valid_async", 64'(out_valid), 64'd0);
    #20 reset = 1'b1;
    @(posedge clock); #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);

    // Directed single operations
    for (int i = 0; i < 10; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].acc, TW'(i + 1), ACC_EN ? vecs[i].exp_acc : vecs[i].exp_mul);
    end
    @(posedge clock); #1;

    // Back-to-back throughput, one result per cycle
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, vecs[c].sgn, vecs[c].op, vecs[c].a, vecs[c].b, 64'd0, TW'(c + 10));
      else       in_valid = 1'b0;
      #1;
      if (c < 4) check_eq($sformatf("tput%0d_in_ready", c), 64'(in_ready), 64'd1);
      if (c >= 2) begin
        check_eq($sformatf("tput%0d_valid", c), 64'(out_valid), 64'd1);
        check_eq($sformatf("tput%0d_result", c), out_result, vecs[c-2].exp_mul);
        check_eq($sformatf("tput%0d_tag", c), 64'(out_tag), 64'(c + 8));
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    check_eq("tput_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: four requests, consumer stalls while the first result waits
    exp_res[0] = 64'd6; exp_res[1] = 64'd9; exp_res[2] = 64'd12; exp_res[3] = 64'd15;
    sent = 0; got = 0; have_prev = 1'b0; prev_res = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (sent < 4) drive(1'b1, 1'b0, 2'b00, 32'(sent + 2), 32'd3, 64'd0, TW'(sent + 1));
      else          in_valid = 1'b0;
      out_ready = (cyc >= 5);
      #1;
      if (cyc >= 2 && cyc <= 4) check_eq($sformatf("stall%0d_in_ready", cyc), 64'(in_ready), 64'd0);
      if (out_valid && !out_ready) begin
        if (have_prev) begin
          check_eq($sformatf("stall%0d_hold_result", cyc), out_result, prev_res);
          check_eq($sformatf("stall%0d_hold_tag", cyc), 64'(out_tag), 64'(prev_tag));
        end
        prev_res = out_result; prev_tag = out_tag; have_prev = 1'b1;
      end
      if (out_valid && out_ready) begin
        check_eq($sformatf("stall_out%0d_tag", got), 64'(out_tag), 64'(got + 1));
        check_eq($sformatf("stall_out%0d_result", got), out_result, exp_res[got]);
        got++;
        have_prev = 1'b0;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check_eq("stall_count", 64'(got), 64'd4);
    @(posedge clock); #1;
    check_eq("stall_drain_valid", 64'(out_valid), 64'd0);

    // Flush with two operations in flight
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 32'd2, 32'd3, 64'd0, TW'(5));
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 2'b00, 32'd4, 32'd3, 64'd0, TW'(6));
    @(posedge clock); #1;
    check_eq("flush_pre_valid", 64'(out_valid), 64'd1);
    drive(1'b1, 1'b0, 2'b00, 32'd7, 32'd7, 64'd0, TW'(7));
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("flush_post%0d_valid", c), 64'(out_valid), 64'd0);
      @(posedge clock); #1;
    end
    run_single("post_flush", 1'b0, 2'b00, 32'd9, 32'd9, 64'd0, TW'(8), 64'd81);
    @(posedge clock); #1;

    // Reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 32'd11, 32'd11, 64'd0, TW'(9));
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 2'b00, 32'd12, 32'd12, 64'd0, TW'(10));
    @(posedge clock); #1;
    in_valid = 1'b0;
    check_eq("rst_mid_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_mid_async_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #3;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      check_eq($sformatf("rst_mid_post%0d_valid", c), 64'(out_valid), 64'd0);
    end
    run_single("post_reset", 1'b1, 2'b00, 32'hFFFF_FFF0, 32'd16, 64'd0, TW'(11), 64'hFFFF_FFFF_FFFF_FF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_multiplier.md
PIPELINED_MULTIPLIER -- requirements
Module: pipelined_multiplier

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width (even, >= 4).
REQ-002 SHALL have parameter TAG_WIDTH, default 5, width of the sideband tag carried with each operation (destination register id).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  discard all in-flight operations.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready & ~flush.
REQ-008 SHALL have port in_signed  input  1  operands two's-complement when 1, unsigned when 0.
REQ-009 SHALL have port in_op  input  2  operation: 00 MUL, 01 MADD, 10 MSUB, 11 treated as MUL.
REQ-010 SHALL have port in_src1 and in_src2  input  DATA_WIDTH each  multiplicand and multiplier.
REQ-011 SHALL have port in_acc  input  2*DATA_WIDTH  accumulator operand for MADD/MSUB.
REQ-012 SHALL have port in_tag  input  TAG_WIDTH  sideband, returned unchanged.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-015 SHALL have port out_result  output  2*DATA_WIDTH  result; out_tag  output  TAG_WIDTH  tag of that result.

Function
REQ-016 Product SHALL be src1*src2 with operands sign- or zero-extended per in_signed, truncated to 2*DATA_WIDTH bits.
REQ-017 MADD SHALL return (in_acc + product) mod 2^(2*DATA_WIDTH); MSUB SHALL return (in_acc - product) mod 2^(2*DATA_WIDTH); no overflow flag.
REQ-018 Partial products SHALL be radix-4 Booth encoded (DATA_WIDTH/2+1 rows) and reduced by a carry-save tree followed by one carry-propagate add.
REQ-019 Pipeline SHALL have two stages: S1 registers Booth rows, negate bits, op, tag; S2 registers reduced and accumulated result (output register).
REQ-020 Latency SHALL be 2 cycles: request accepted at edge N gives out_valid at edge N+2 when not stalled.
REQ-021 Throughput SHALL be one operation per cycle when out_ready stays 1.
REQ-022 S2 SHALL advance when ~out_valid | out_ready; S1 SHALL advance when ~s1_valid | S2 advances; in_ready SHALL equal the S1 advance condition (combinational, may depend on out_ready).
REQ-023 When stalled, out_result/out_tag SHALL hold stable while out_valid=1; results SHALL emerge in acceptance order with none lost or duplicated.
REQ-024 flush=1 SHALL clear both stage valid bits at the next edge and block acceptance that cycle; out_valid SHALL be 0 the cycle after flush.
REQ-025 A result handshaken (out_valid & out_ready) in the same cycle as flush SHALL count as delivered.

Reset
REQ-026 On reset low, s1_valid and out_valid SHALL clear immediately (asynchronously); in_ready SHALL read 1 after reset deasserts.
REQ-027 Data registers (result, tag, rows) need no reset; out_result SHALL be don't-care while out_valid=0.
REQ-028 Reset asserted mid-operation SHALL drop all in-flight operations; no result for them SHALL appear afterwards.

Configuration
REQ-029 Macro MULTIPLIER_ACCUMULATE_EN defined: MADD/MSUB per REQ-017, in_acc added into the reduction tree as an extra row.
REQ-030 Macro undefined: in_op and in_acc SHALL be ignored, every operation SHALL behave as MUL, and no accumulate logic SHALL be built; ports remain.

Structure
REQ-031 Package multiplier_params SHALL hold the mul_op_t enum (MUL, MADD, MSUB) and the default width constants; stage bus structs are local to the module since they depend on parameters.
REQ-032 One sub-module, booth_partial_product, SHALL generate one Booth row (select, negate, sign extension) and be instantiated DATA_WIDTH/2+1 times.

Verification
REQ-033 Unsigned MUL 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001 two cycles after acceptance; signed same operands -> 0x00000000_00000001.
REQ-034 Signed MUL 0x80000000*0x80000000 -> 0x40000000_00000000; signed 0x80000000*0x00000001 -> 0xFFFFFFFF_80000000.
REQ-035 MADD acc=1, 7*6 -> 43; MSUB acc=0, 3*5 -> 0xFFFFFFFF_FFFFFFF1; with macro undefined both -> product (42, 15).
REQ-036 Four back-to-back requests, tags 1..4, out_ready low 3 cycles: in_ready drops after two accepted, outputs hold stable, tags then return 1,2,3,4 in order.
REQ-037 Two requests in flight, flush pulsed one cycle: no out_valid for either; request accepted the next cycle returns correctly after 2 cycles.
REQ-038 Reset pulsed low with S1 and S2 full: out_valid falls without a clock edge; no stale result after release.
